// File: rtl/servo_sweep_pkg.sv
// Shared types for the servo sweep generator: sweep FSM states and mode encodings.
package servo_sweep_pkg;

    typedef enum logic [1:0] {
        SOBE      = 2'd0,
        DESCE     = 2'd1,
        PARA_TOPO = 2'd2,
        PARA_BASE = 2'd3
    } estado_t;

    localparam logic MODO_TRIANGULO = 1'b0;
    localparam logic MODO_SERRA     = 1'b1;

endpackage

// File: rtl/sweep_dwell_counter.sv
// End-point dwell counter: cleared by load, advanced by step, saturates at TERM.
module sweep_dwell_counter #(
    parameter int TERM = 2,
    parameter int W    = $clog2(TERM + 1)
) (
    input  logic clock_i,
    input  logic zera_s_n_i,
    input  logic load_i,
    input  logic step_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o = (cnt_q == W'(TERM));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (step_i && !tc_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!zera_s_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/servo_sweep_gen.sv
// Triangle/sawtooth servo position sweep with top (meio) and period-end (fim) pulses.
// Defining SERVO_SWEEP_DWELL_EN adds a DWELL-step hold at each end point.
module servo_sweep_gen
    import servo_sweep_pkg::*;
#(
    parameter int N     = 3,
    parameter int MIN   = 0,
    parameter int MAX   = 7,
    parameter int DWELL = 2
) (
    input  logic         clock,
    input  logic         zera_s_n,
    input  logic         conta,
    input  logic         modo,
    output logic [N-1:0] value,
    output logic         sentido,
    output logic         meio,
    output logic         fim
);

    localparam logic [N-1:0] MIN_V = N'(MIN);
    localparam logic [N-1:0] MAX_V = N'(MAX);
    localparam logic [N-1:0] ONE_V = N'(1);

    if (MIN < 0 || MIN >= MAX || MAX > (2 ** N) - 1 || DWELL < 1) begin : g_param_check
        $error("servo_sweep_gen: illegal N/MIN/MAX/DWELL combination");
    end

    estado_t      state_q, state_d;
    logic [N-1:0] value_q, value_d;
    logic         sentido_q, sentido_d;
    logic         meio_q, meio_d;
    logic         fim_q, fim_d;

    logic [N-1:0] up_v;
    logic [N-1:0] dn_v;
    logic         go_up;
    logic         go_dn;
    logic         wrap;

    assign up_v = value_q + ONE_V;
    assign dn_v = value_q - ONE_V;

`ifdef SERVO_SWEEP_DWELL_EN
    logic cnt_load;
    logic cnt_step;
    logic cnt_tc;

    sweep_dwell_counter #(
        .TERM (DWELL)
    ) u_dwell (
        .clock_i    (clock),
        .zera_s_n_i (zera_s_n),
        .load_i     (cnt_load),
        .step_i     (cnt_step),
        .tc_o       (cnt_tc)
    );
`endif

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        sentido_d = sentido_q;
        meio_d    = 1'b0;
        fim_d     = 1'b0;
        go_up     = 1'b0;
        go_dn     = 1'b0;
        wrap      = 1'b0;
`ifdef SERVO_SWEEP_DWELL_EN
        cnt_load  = 1'b0;
        cnt_step  = 1'b0;
`endif

        if (conta) begin
            // First pick the kind of move, then apply its common side effects below.
            case (state_q)
                SOBE, DESCE: begin
                    if (modo == MODO_SERRA) begin
                        if (value_q == MAX_V) wrap  = 1'b1;
                        else                  go_up = 1'b1;
                    end else if (state_q == SOBE) begin
                        if (value_q == MAX_V) go_dn = 1'b1;
                        else                  go_up = 1'b1;
                    end else begin
                        if (value_q == MIN_V) go_up = 1'b1;
                        else                  go_dn = 1'b1;
                    end
                end
`ifdef SERVO_SWEEP_DWELL_EN
                PARA_TOPO: begin
                    if (!cnt_tc)                   cnt_step = 1'b1;
                    else if (modo == MODO_SERRA)   wrap     = 1'b1;
                    else                           go_dn    = 1'b1;
                end
                PARA_BASE: begin
                    if (!cnt_tc) cnt_step = 1'b1;
                    else         go_up    = 1'b1;
                end
`endif
                default: state_d = SOBE;
            endcase

            if (go_up) begin
                value_d   = up_v;
                state_d   = SOBE;
                sentido_d = 1'b1;
                if (up_v == MAX_V) begin
                    meio_d = 1'b1;
                    if (modo == MODO_TRIANGULO) begin
                        state_d   = DESCE;
                        sentido_d = 1'b0;
                    end
`ifdef SERVO_SWEEP_DWELL_EN
                    state_d  = PARA_TOPO;
                    cnt_load = 1'b1;
`endif
                end
            end

            if (go_dn) begin
                value_d   = dn_v;
                state_d   = DESCE;
                sentido_d = 1'b0;
                if (dn_v == MIN_V) begin
                    fim_d     = 1'b1;
                    state_d   = SOBE;
                    sentido_d = 1'b1;
`ifdef SERVO_SWEEP_DWELL_EN
                    state_d  = PARA_BASE;
                    cnt_load = 1'b1;
`endif
                end
            end

            if (wrap) begin
                value_d   = MIN_V;
                state_d   = SOBE;
                sentido_d = 1'b1;
                fim_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!zera_s_n) begin
            state_q   <= SOBE;
            value_q   <= MIN_V;
            sentido_q <= 1'b1;
            meio_q    <= 1'b0;
            fim_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            sentido_q <= sentido_d;
            meio_q    <= meio_d;
            fim_q     <= fim_d;
        end
    end

    assign value   = value_q;
    assign sentido = sentido_q;
    assign meio    = meio_q;
    assign fim     = fim_q;

endmodule

// File: tb/tb_servo_sweep_gen.sv
// Table-driven directed bench: default-parameter instance plus an N=5/3..20 sawtooth instance.
module tb_servo_sweep_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n = 1'b0, a_conta = 1'b0, a_modo = 1'b0;
    logic [2:0] a_value;
    logic       a_sentido, a_meio, a_fim;
    logic       b_rst_n = 1'b0, b_conta = 1'b0, b_modo = 1'b1;
    logic [4:0] b_value;
    logic       b_sentido, b_meio, b_fim;

    bit         run_done = 1'b0;

    servo_sweep_gen u_a (
        .clock    (clk),
        .zera_s_n (a_rst_n),
        .conta    (a_conta),
        .modo     (a_modo),
        .value    (a_value),
        .sentido  (a_sentido),
        .meio     (a_meio),
        .fim      (a_fim)
    );

    servo_sweep_gen #(.N(5), .MIN(3), .MAX(20)) u_b (
        .clock    (clk),
        .zera_s_n (b_rst_n),
        .conta    (b_conta),
        .modo     (b_modo),
        .value    (b_value),
        .sentido  (b_sentido),
        .meio     (b_meio),
        .fim      (b_fim)
    );

    typedef struct {
        bit       sel;
        bit       rst_n;
        bit       conta;
        bit       modo;
        int       value;
        bit       sentido;
        bit       meio;
        bit       fim;
        string    tag;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(bit sel, bit rst_n, bit conta, bit modo,
                                int value, bit sentido, bit meio, bit fim, string tag);
        vec_t v;
        v.sel = sel; v.rst_n = rst_n; v.conta = conta; v.modo = modo;
        v.value = value; v.sentido = sentido; v.meio = meio; v.fim = fim; v.tag = tag;
        vecs.push_back(v);
    endfunction

    initial begin
        #100000;
        if (!run_done) begin
            $display("FAIL timeout: vector sequence did not complete within 100000 time units");
            $finish;
        end
    end

    initial begin
`ifndef SERVO_SWEEP_DWELL_EN
        int tri_v[14] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
        bit tri_s[14] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
`else
        int dw_v[18] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0};
        bit dw_s[18] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
`endif
        int   got_v;
        bit   got_s, got_m, got_f;

        // ---------------- reset-state check on both instances ----------------
        a_rst_n = 1'b0; a_conta = 1'b0; a_modo = 1'b0;
        b_rst_n = 1'b0; b_conta = 1'b0; b_modo = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (a_value !== 3'd0 || a_sentido !== 1'b1 || a_meio !== 1'b0 || a_fim !== 1'b0 ||
            b_value !== 5'd3 || b_sentido !== 1'b1 || b_meio !== 1'b0 || b_fim !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: a value=%0d sentido=%0d meio=%0d fim=%0d, b value=%0d sentido=%0d meio=%0d fim=%0d",
                     a_value, a_sentido, a_meio, a_fim, b_value, b_sentido, b_meio, b_fim);
        end else begin
            $display("reset_state: a value=%0d sentido=%0d, b value=%0d sentido=%0d",
                     a_value, a_sentido, b_value, b_sentido);
        end

        // ---------------- instance A (defaults) ----------------
        add(0, 0, 1, 0, 0, 1, 0, 0, "a_reset");
`ifndef SERVO_SWEEP_DWELL_EN
        for (int k = 0; k < 28; k++)
            add(0, 1, 1, 0, tri_v[k % 14], tri_s[k % 14], (k % 14) == 6, (k % 14) == 13, "tri28");
        add(0, 1, 1, 0, 1, 1, 0, 0, "tog_up");
        add(0, 1, 0, 0, 1, 1, 0, 0, "tog_hold");
        add(0, 1, 1, 0, 2, 1, 0, 0, "tog_up");
        add(0, 1, 0, 0, 2, 1, 0, 0, "tog_hold");
        for (int k = 3; k <= 6; k++)
            add(0, 1, 1, 0, k, 1, 0, 0, "climb");
        add(0, 1, 1, 0, 7, 0, 1, 0, "top_meio");
        add(0, 1, 0, 0, 7, 0, 0, 0, "meio_drop");
        add(0, 1, 1, 0, 6, 0, 0, 0, "down");
        add(0, 1, 0, 0, 6, 0, 0, 0, "down_hold");
        add(0, 1, 1, 0, 5, 0, 0, 0, "down");
        add(0, 1, 1, 1, 6, 1, 0, 0, "sw_serra");
        add(0, 1, 1, 1, 7, 1, 1, 0, "serra_max");
        add(0, 1, 1, 1, 0, 1, 0, 1, "serra_wrap");
        add(0, 1, 0, 1, 0, 1, 0, 0, "fim_drop");
        add(0, 1, 1, 1, 1, 1, 0, 0, "serra_up");
        add(0, 1, 1, 0, 2, 1, 0, 0, "sw_tri");
        for (int k = 3; k <= 6; k++)
            add(0, 1, 1, 0, k, 1, 0, 0, "climb");
        add(0, 1, 1, 0, 7, 0, 1, 0, "top_meio");
        add(0, 1, 1, 0, 6, 0, 0, 0, "down");
        add(0, 0, 1, 0, 0, 1, 0, 0, "rst_mid");
        add(0, 1, 1, 0, 1, 1, 0, 0, "post_rst");
`else
        for (int k = 0; k < 18; k++)
            add(0, 1, 1, 0, dw_v[k], dw_s[k], k == 6, k == 15, "dwell18");
        add(0, 1, 1, 0, 1, 1, 0, 0, "leave_base");
        for (int k = 2; k <= 6; k++)
            add(0, 1, 1, 0, k, 1, 0, 0, "climb");
        add(0, 1, 1, 0, 7, 0, 1, 0, "top_meio");
        add(0, 1, 0, 0, 7, 0, 0, 0, "dwell_idle");
        add(0, 1, 1, 0, 7, 0, 0, 0, "dwell_hold");
        add(0, 0, 1, 0, 0, 1, 0, 0, "rst_dwell");
        add(0, 1, 1, 0, 1, 1, 0, 0, "post_rst");
`endif

        // ---------------- instance B (N=5, 3..20, sawtooth) ----------------
        add(1, 0, 1, 1, 3, 1, 0, 0, "b_reset");
        for (int k = 1; k <= 17; k++)
            add(1, 1, 1, 1, 3 + k, 1, k == 17, 0, "saw_up");
`ifdef SERVO_SWEEP_DWELL_EN
        add(1, 1, 1, 1, 20, 1, 0, 0, "saw_dwell");
        add(1, 1, 1, 1, 20, 1, 0, 0, "saw_dwell");
`endif
        add(1, 1, 1, 1, 3, 1, 0, 1, "saw_wrap");
        add(1, 1, 1, 1, 4, 1, 0, 0, "saw_again");

        foreach (vecs[i]) begin
            if (vecs[i].sel) begin
                b_rst_n = vecs[i].rst_n; b_conta = vecs[i].conta; b_modo = vecs[i].modo;
                a_rst_n = 1'b1;          a_conta = 1'b0;
            end else begin
                a_rst_n = vecs[i].rst_n; a_conta = vecs[i].conta; a_modo = vecs[i].modo;
                b_rst_n = 1'b1;          b_conta = 1'b0;
            end
            @(posedge clk);
            #1;
            if (vecs[i].sel) begin
                got_v = int'(b_value); got_s = b_sentido; got_m = b_meio; got_f = b_fim;
            end else begin
                got_v = int'(a_value); got_s = a_sentido; got_m = a_meio; got_f = a_fim;
            end
            total++;
            if (got_v !== vecs[i].value || got_s !== vecs[i].sentido ||
                got_m !== vecs[i].meio  || got_f !== vecs[i].fim) begin
                bad++;
                $display("FAIL vec%0d %s: got value=%0d sentido=%0d meio=%0d fim=%0d, need value=%0d sentido=%0d meio=%0d fim=%0d",
                         i, vecs[i].tag, got_v, got_s, got_m, got_f,
                         vecs[i].value, vecs[i].sentido, vecs[i].meio, vecs[i].fim);
            end else begin
                $display("vec%0d %s: value=%0d sentido=%0d meio=%0d fim=%0d",
                         i, vecs[i].tag, got_v, got_s, got_m, got_f);
            end
        end

        run_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
